rmii_frame_rx: RTL and testbench
================================

RMII_FRAME_RX -- requirements
Module: rmii_frame_rx

Interface
REQ-001 Parameter DW, default 2: bits per clock on the line (2 = RMII, 4 = MII); only 2 and 4 are legal.
REQ-002 Parameter MIN_LEN, default 64: minimum legal frame bytes after the SFD, FCS included.
REQ-003 Parameter MAX_LEN, default 1522: maximum legal frame bytes after the SFD, FCS included.
REQ-004 clk  in  1  line clock; the only clock.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 rx_en  in  1  line enable (txen/crs_dv of the observed link).
REQ-007 rx_d  in  DW  line data, LSB-first.
REQ-008 m_data  out  8  received payload byte; FCS bytes are never emitted.
REQ-009 m_valid  out  1  one-cycle strobe qualifying m_data.
REQ-010 m_sof  out  1  high with m_valid on the first payload byte of a frame.
REQ-011 f_done  out  1  one-cycle end-of-frame status strobe.
REQ-012 f_len  out  11  frame bytes after the SFD, FCS included; valid with f_done.
REQ-013 f_err  out  4  error flags {long, crc, short, incomplete}; valid with f_done; 0 = good frame.
REQ-014 frame_cnt  out  32  count of f_done strobes with f_err == 0.
REQ-015 err_cnt  out  32  count of f_done strobes with f_err != 0.

Function
REQ-016 The FSM SHALL have states IDLE, PRE, DATA and DONE.
REQ-017 IDLE -> PRE when rx_en = 1; PRE -> IDLE when rx_en = 0, and the preamble shift register clears.
REQ-018 PRE SHALL shift rx_d into a 64-bit register from the MSB end and go to DATA on the cycle it equals 64'hD555555555555555 (7 x 0x55, then SFD 0xD5).
REQ-019 DATA SHALL assemble one byte every 8/DW cycles LSB-first and increment the byte count, which saturates at 2047.
REQ-020 Each completed byte SHALL enter a 4-byte delay line; a byte leaving the line SHALL be emitted on m_data/m_valid and fed to crc32 the same cycle.
REQ-021 m_sof SHALL mark the first emitted byte of each frame only.
REQ-022 DATA -> DONE on the first cycle rx_en = 0.
REQ-023 DONE SHALL last two cycles so the registered crc32 output settles, then assert f_done and return to IDLE.
REQ-024 f_done SHALL therefore occur exactly 2 cycles after the cycle that sampled rx_en = 0 in DATA.
REQ-025 incomplete SHALL be set when a partial byte is pending at rx_en fall.
REQ-026 short SHALL be set when f_len < MIN_LEN.
REQ-027 long SHALL be set when f_len > MAX_LEN; bytes keep being emitted after MAX_LEN.
REQ-028 crc SHALL be set when f_len < 4, or when the byte-swapped crc32 result differs from the 4 bytes held in the delay line.
REQ-029 Several f_err bits MAY be set in one frame.
REQ-030 A new preamble during DONE SHALL be ignored; detection restarts in IDLE.
REQ-031 frame_cnt and err_cnt SHALL wrap modulo 2^32.
REQ-032 Outputs SHALL be registered; m_valid, m_sof and f_done are never high for more than one consecutive cycle per event.

Reset
REQ-033 rst SHALL force IDLE and clear the shift register, delay line, byte count and crc32 state.
REQ-034 rst SHALL zero m_data, m_valid, m_sof, f_done, f_len, f_err, frame_cnt and err_cnt.
REQ-035 A reset mid-frame SHALL abort the frame without an f_done strobe.

Structure
REQ-036 The preamble/SFD constant, the f_err bit indices and the bswap32 function SHALL live in the shared util header.
REQ-037 The block SHALL instantiate the existing byte-wide crc32 sub-module (clk, rst, vld, data, crc).
REQ-038 The block SHALL be synthesizable, with no delays or tasks.

Verification
REQ-039 Good frame: DW=2, 64 bytes after the SFD with a correct FCS -> 60 m_valid beats, m_sof on the first, f_done with f_len=64 and f_err=0, frame_cnt=1.
REQ-040 CRC error: the same frame with bit 0 of byte 10 flipped -> f_err=4'b0100, err_cnt=1.
REQ-041 Short/incomplete: a 40-byte frame, then a 64-byte frame with one extra dibble -> f_err=4'b0010 (or 4'b0110 if the FCS is wrong), then f_err bit0=1.
REQ-042 Long/MII: DW=4, a 1600-byte correct-FCS frame -> 1596 beats, f_len=1600, f_err=4'b1000.
REQ-043 Preamble robustness: only 6 x 0x55 before the SFD -> no m_valid and no f_done; a following correct frame is received normally.
REQ-044 Reset abort: assert rst at payload byte 30 -> all outputs 0 the next cycle, no f_done, and the next frame is received correctly.

Source files
------------

// File: rtl/rmii_frame_rx_pkg.sv
// Shared definitions for the RMII/MII frame receiver: FSM states, the preamble/SFD
// pattern, f_err bit positions and the byte-swap / CRC-32 step helpers.
package rmii_frame_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } rx_state_e;

   // Seven 0x55 preamble bytes then the 0xD5 SFD, first line bit at bit 0.
   localparam logic [63:0] PREAMBLE_SFD = 64'hD555555555555555;

   localparam int ERR_INCOMPLETE = 0;
   localparam int ERR_SHORT      = 1;
   localparam int ERR_CRC        = 2;
   localparam int ERR_LONG       = 3;

   localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;

   function automatic logic [31:0] bswap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   // One byte of the reflected Ethernet CRC-32 update.
   function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ CRC_POLY_REFL) : (r >> 1);
      end
      return r;
   endfunction

endpackage

// File: rtl/rmii_frame_rx_crc32.sv
// Byte-wide Ethernet CRC-32 accumulator; crc is the complemented running state,
// i.e. the FCS value whose low byte goes on the wire first.
module rmii_frame_rx_crc32
   import rmii_frame_rx_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        vld,
   input  logic [7:0]  data,
   output logic [31:0] crc
);

   logic [31:0] state_q;

   // Running CRC state, reseeded to all ones by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= 32'hFFFF_FFFF;
      end else if (vld) begin
         state_q <= crc32_byte(state_q, data);
      end else begin
         state_q <= state_q;
      end
   end

   assign crc = ~state_q;

endmodule

// File: rtl/rmii_frame_rx.sv
// RMII/MII receive framer: preamble/SFD hunt, LSB-first byte assembly, FCS strip
// through a 4-byte delay line, FCS check, per-frame status and frame counters.
module rmii_frame_rx
   import rmii_frame_rx_pkg::*;
#(
   parameter int DW      = 2,
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1522
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rx_en,
   input  logic [DW-1:0] rx_d,
   output logic [7:0]    m_data,
   output logic          m_valid,
   output logic          m_sof,
   output logic          f_done,
   output logic [10:0]   f_len,
   output logic [3:0]    f_err,
   output logic [31:0]   frame_cnt,
   output logic [31:0]   err_cnt
);

   localparam int          PRE_W     = 64 - DW;
   localparam int          SH_W      = 8 - DW;
   localparam logic [1:0]  LAST_BEAT = 2'(8 / DW - 1);
   localparam logic [10:0] MIN_LEN_C = 11'(MIN_LEN);
   localparam logic [10:0] MAX_LEN_C = 11'(MAX_LEN);
   localparam logic [10:0] CNT_SAT   = 11'd2047;

   rx_state_e        state_q, state_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [SH_W-1:0]  sh_q, sh_d;
   logic [1:0]       beat_q, beat_d;
   logic [10:0]      cnt_q, cnt_d;
   logic [3:0][7:0]  dl_q, dl_d;
   logic             done_q, done_d;
   logic             crc_clr_q, crc_clr_d;
   logic [7:0]       m_data_q, m_data_d;
   logic             m_valid_q, m_valid_d;
   logic             m_sof_q, m_sof_d;
   logic             f_done_q, f_done_d;
   logic [10:0]      f_len_q, f_len_d;
   logic [3:0]       f_err_q, f_err_d;
   logic [31:0]      frame_cnt_q, frame_cnt_d;
   logic [31:0]      err_cnt_q, err_cnt_d;

   logic [63:0]      pre_shift_s;
   logic [7:0]       byte_s;
   logic [3:0]       err_s;
   logic [31:0]      crc_s;
   logic             crc_rst_s;

   // Only the upper 64-DW bits are stored; the newest dibble completes the window.
   assign pre_shift_s = {rx_d, pre_q};
   assign byte_s      = {rx_d, sh_q};
   // The CRC is held at its seed whenever no frame body is in progress.
   assign crc_rst_s   = rst | crc_clr_q;

   rmii_frame_rx_crc32 u_crc32 (
      .clk  (clk),
      .rst  (crc_rst_s),
      .vld  (m_valid_q),
      .data (m_data_q),
      .crc  (crc_s)
   );

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pre_q       <= {PRE_W{1'b0}};
         sh_q        <= {SH_W{1'b0}};
         beat_q      <= 2'd0;
         cnt_q       <= 11'd0;
         dl_q        <= 32'd0;
         done_q      <= 1'b0;
         crc_clr_q   <= 1'b1;
         m_data_q    <= 8'd0;
         m_valid_q   <= 1'b0;
         m_sof_q     <= 1'b0;
         f_done_q    <= 1'b0;
         f_len_q     <= 11'd0;
         f_err_q     <= 4'd0;
         frame_cnt_q <= 32'd0;
         err_cnt_q   <= 32'd0;
      end else begin
         state_q     <= state_d;
         pre_q       <= pre_d;
         sh_q        <= sh_d;
         beat_q      <= beat_d;
         cnt_q       <= cnt_d;
         dl_q        <= dl_d;
         done_q      <= done_d;
         crc_clr_q   <= crc_clr_d;
         m_data_q    <= m_data_d;
         m_valid_q   <= m_valid_d;
         m_sof_q     <= m_sof_d;
         f_done_q    <= f_done_d;
         f_len_q     <= f_len_d;
         f_err_q     <= f_err_d;
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   // Next-state, byte assembly, delay line and end-of-frame status.
   always_comb begin
      state_d     = state_q;
      pre_d       = pre_q;
      sh_d        = sh_q;
      beat_d      = beat_q;
      cnt_d       = cnt_q;
      dl_d        = dl_q;
      done_d      = done_q;
      m_data_d    = m_data_q;
      m_valid_d   = 1'b0;
      m_sof_d     = 1'b0;
      f_done_d    = 1'b0;
      f_len_d     = f_len_q;
      f_err_d     = f_err_q;
      frame_cnt_d = frame_cnt_q;
      err_cnt_d   = err_cnt_q;
      err_s       = 4'd0;

      case (state_q)
         ST_IDLE: begin
            if (rx_en) begin
               pre_d   = pre_shift_s[63:DW];
               state_d = ST_PRE;
            end else begin
               pre_d = {PRE_W{1'b0}};
            end
         end
         ST_PRE: begin
            if (!rx_en) begin
               pre_d   = {PRE_W{1'b0}};
               state_d = ST_IDLE;
            end else if (pre_shift_s == PREAMBLE_SFD) begin
               pre_d   = {PRE_W{1'b0}};
               sh_d    = {SH_W{1'b0}};
               beat_d  = 2'd0;
               cnt_d   = 11'd0;
               state_d = ST_DATA;
            end else begin
               pre_d = pre_shift_s[63:DW];
            end
         end
         ST_DATA: begin
            if (!rx_en) begin
               done_d  = 1'b0;
               state_d = ST_DONE;
            end else begin
               sh_d = byte_s[7:DW];
               if (beat_q == LAST_BEAT) begin
                  beat_d = 2'd0;
                  cnt_d  = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 11'd1;
                  dl_d   = {dl_q[2:0], byte_s};
                  // Once four bytes are held, each new byte pushes out a payload byte.
                  if (cnt_q >= 11'd4) begin
                     m_data_d  = dl_q[3];
                     m_valid_d = 1'b1;
                     m_sof_d   = (cnt_q == 11'd4);
                  end else begin
                     m_data_d = m_data_q;
                  end
               end else begin
                  beat_d = beat_q + 2'd1;
               end
            end
         end
         ST_DONE: begin
            if (!done_q) begin
               done_d = 1'b1;
            end else begin
               done_d                = 1'b0;
               state_d               = ST_IDLE;
               err_s[ERR_INCOMPLETE] = (beat_q != 2'd0);
               err_s[ERR_SHORT]      = (cnt_q < MIN_LEN_C);
               err_s[ERR_LONG]       = (cnt_q > MAX_LEN_C);
               err_s[ERR_CRC]        = (cnt_q < 11'd4) || (bswap32(crc_s) != dl_q);
               f_done_d              = 1'b1;
               f_len_d               = cnt_q;
               f_err_d               = err_s;
               if (err_s == 4'd0) begin
                  frame_cnt_d = frame_cnt_q + 32'd1;
               end else begin
                  err_cnt_d = err_cnt_q + 32'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      crc_clr_d = (state_d == ST_IDLE) || (state_d == ST_PRE);
   end

   assign m_data    = m_data_q;
   assign m_valid   = m_valid_q;
   assign m_sof     = m_sof_q;
   assign f_done    = f_done_q;
   assign f_len     = f_len_q;
   assign f_err     = f_err_q;
   assign frame_cnt = frame_cnt_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_rmii_frame_rx.sv
// Bench for rmii_frame_rx: one RMII (DW=2) and one MII (DW=4) instance driven with
// directed and random frames, checked against a frame-level reference model.
module tb_rmii_frame_rx;

   typedef logic [7:0] bq_t[$];

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_en [2];
   logic [1:0] rx_d2;
   logic [3:0] rx_d4;
   logic [7:0]  m_data [2];
   logic        m_valid [2];
   logic        m_sof [2];
   logic        f_done [2];
   logic [10:0] f_len [2];
   logic [3:0]  f_err [2];
   logic [31:0] frame_cnt [2];
   logic [31:0] err_cnt [2];

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   logic [8:0]  exp_q [2][$];
   int          exp_done_cyc [2] = '{-1, -1};
   logic [10:0] exp_len [2];
   logic [3:0]  exp_err [2];
   logic [31:0] mfc [2] = '{32'd0, 32'd0};
   logic [31:0] mec [2] = '{32'd0, 32'd0};
   int          beats [2] = '{0, 0};
   int          done_seen [2] = '{0, 0};
   logic [10:0] last_len [2];
   logic [3:0]  last_err [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rmii_frame_rx #(.DW(2), .MIN_LEN(64), .MAX_LEN(1522)) dut2 (
      .clk(clk), .rst(rst), .rx_en(rx_en[0]), .rx_d(rx_d2),
      .m_data(m_data[0]), .m_valid(m_valid[0]), .m_sof(m_sof[0]), .f_done(f_done[0]),
      .f_len(f_len[0]), .f_err(f_err[0]), .frame_cnt(frame_cnt[0]), .err_cnt(err_cnt[0]));

   rmii_frame_rx #(.DW(4), .MIN_LEN(64), .MAX_LEN(1522)) dut4 (
      .clk(clk), .rst(rst), .rx_en(rx_en[1]), .rx_d(rx_d4),
      .m_data(m_data[1]), .m_valid(m_valid[1]), .m_sof(m_sof[1]), .f_done(f_done[1]),
      .f_len(f_len[1]), .f_err(f_err[1]), .frame_cnt(frame_cnt[1]), .err_cnt(err_cnt[1]));

   task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: got %0h, expected %0h", nm, inst, act, exp);
      end
   endtask

   // Ethernet CRC-32 in the MSB-first shift form with bits fed LSB-first per byte.
   function automatic logic [31:0] ref_crc(input bq_t fb, input int len);
      logic [31:0] c;
      logic [31:0] r;
      logic        fbk;
      c = 32'hFFFF_FFFF;
      for (int k = 0; k < len; k++) begin
         for (int j = 0; j < 8; j++) begin
            fbk = c[31] ^ fb[k][j];
            c   = {c[30:0], 1'b0} ^ (fbk ? 32'h04C1_1DB7 : 32'h0);
         end
      end
      for (int j = 0; j < 32; j++) r[j] = c[31-j];
      return ~r;
   endfunction

   function automatic bq_t make_frame(input int plen);
      bq_t         fb;
      logic [31:0] c;
      for (int k = 0; k < plen; k++) fb.push_back(8'($urandom));
      c = ref_crc(fb, plen);
      for (int k = 0; k < 4; k++) fb.push_back(c[8*k +: 8]);
      return fb;
   endfunction

   function automatic logic [3:0] model_err(input bq_t fb, input int extra);
      int          n;
      logic [3:0]  e;
      logic [31:0] fcs;
      n    = fb.size();
      e    = 4'd0;
      e[0] = (extra != 0);
      e[1] = (n < 64);
      e[3] = (n > 1522);
      if (n < 4) begin
         e[2] = 1'b1;
      end else begin
         fcs  = {fb[n-1], fb[n-2], fb[n-3], fb[n-4]};
         e[2] = (ref_crc(fb, n - 4) != fcs);
      end
      return e;
   endfunction

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      logic [8:0] e;
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            if (m_valid[i]) begin
               beats[i]++;
               if (exp_q[i].size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL m_valid[%0d]: unexpected beat data %0h", i, m_data[i]);
               end else begin
                  e = exp_q[i].pop_front();
                  chk("m_data", i, m_data[i], e[7:0]);
                  chk("m_sof", i, m_sof[i], e[8]);
               end
            end else if (m_sof[i]) begin
               chk("m_sof_without_valid", i, m_sof[i], m_valid[i]);
            end
            if (f_done[i] || cyc == exp_done_cyc[i]) begin
               chk("f_done_timing", i, f_done[i], cyc == exp_done_cyc[i]);
               if (f_done[i]) begin
                  done_seen[i]++;
                  last_len[i] = f_len[i];
                  last_err[i] = f_err[i];
               end
               if (cyc == exp_done_cyc[i]) begin
                  chk("f_len", i, f_len[i], exp_len[i]);
                  chk("f_err", i, f_err[i], exp_err[i]);
                  if (exp_err[i] == 4'd0) mfc[i] = mfc[i] + 32'd1;
                  else mec[i] = mec[i] + 32'd1;
                  chk("frame_cnt", i, frame_cnt[i], mfc[i]);
                  chk("err_cnt", i, err_cnt[i], mec[i]);
               end
            end
         end
      end
   end

   task automatic chk_zero_outputs(input string nm);
      for (int i = 0; i < 2; i++) begin
         chk({nm, "_m_data"}, i, m_data[i], 64'd0);
         chk({nm, "_m_valid"}, i, m_valid[i], 64'd0);
         chk({nm, "_m_sof"}, i, m_sof[i], 64'd0);
         chk({nm, "_f_done"}, i, f_done[i], 64'd0);
         chk({nm, "_f_len"}, i, f_len[i], 64'd0);
         chk({nm, "_f_err"}, i, f_err[i], 64'd0);
         chk({nm, "_frame_cnt"}, i, frame_cnt[i], 64'd0);
         chk({nm, "_err_cnt"}, i, err_cnt[i], 64'd0);
      end
   endtask

   task automatic send(input int inst, input bq_t fb, input int n55, input int extra, input int abort_at);
      logic       bq[$];
      logic [7:0] pb;
      logic [3:0] w;
      int         bpc, n, b0, d0, idx, abort_bit;
      bit         det, aborted;
      bpc     = (inst == 0) ? 2 : 4;
      n       = fb.size();
      det     = (n55 == 7);
      aborted = 1'b0;
      b0      = beats[inst];
      d0      = done_seen[inst];
      for (int k = 0; k < n55 + 1 + n; k++) begin
         if (k < n55) pb = 8'h55;
         else if (k == n55) pb = 8'hD5;
         else pb = fb[k-n55-1];
         for (int j = 0; j < 8; j++) bq.push_back(pb[j]);
      end
      for (int k = 0; k < extra * bpc; k++) bq.push_back(1'($urandom));
      if (det) begin
         for (int k = 0; k + 4 < n; k++) exp_q[inst].push_back({(k == 0) ? 1'b1 : 1'b0, fb[k]});
         exp_len[inst] = 11'(n);
         exp_err[inst] = model_err(fb, extra);
      end
      abort_bit = (abort_at < 0) ? -1 : (n55 + 1 + abort_at) * 8;
      idx       = 0;
      while (bq.size() > 0 && !aborted) begin
         @(posedge clk);
         #1;
         if (idx == abort_bit) begin
            rst         = 1'b1;
            rx_en[inst] = 1'b0;
            aborted     = 1'b1;
         end else begin
            w = 4'd0;
            for (int j = 0; j < bpc; j++) w[j] = bq.pop_front();
            rx_en[inst] = 1'b1;
            if (inst == 0) rx_d2 = w[1:0];
            else rx_d4 = w;
            idx += bpc;
         end
      end
      if (aborted) begin
         for (int i = 0; i < 2; i++) begin
            exp_q[i].delete();
            exp_done_cyc[i] = -1;
            mfc[i]          = 32'd0;
            mec[i]          = 32'd0;
         end
         @(negedge clk);
         chk_zero_outputs("abort");
         @(posedge clk);
         #1;
         rst = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         rx_en[inst] = 1'b0;
         if (det) exp_done_cyc[inst] = cyc + 3;
      end
      repeat (8) @(posedge clk);
      #1;
      chk("f_done_count", inst, done_seen[inst] - d0, (det && !aborted) ? 1 : 0);
      if (!aborted) begin
         chk("beat_count", inst, beats[inst] - b0, (det && n > 4) ? n - 4 : 0);
         chk("pending_beats", inst, exp_q[inst].size(), 0);
      end
   endtask

   initial begin
      bq_t fb;
      bq_t ascii;
      int  inst, mode, bpb, pos;
      rx_en[0] = 1'b0;
      rx_en[1] = 1'b0;
      rx_d2    = 2'd0;
      rx_d4    = 4'd0;
      rst      = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_zero_outputs("reset");

      for (int k = 0; k < 9; k++) ascii.push_back(8'h31 + 8'(k));
      chk("crc_pin_123456789", 0, ref_crc(ascii, 9), 32'hCBF4_3926);

      // Good 64-byte frame.
      fb = make_frame(60);
      send(0, fb, 7, 0, -1);
      chk("good_err", 0, last_err[0], 4'b0000);
      chk("good_len", 0, last_len[0], 11'd64);
      chk("good_fcnt", 0, frame_cnt[0], 32'd1);

      // Same frame with bit 0 of byte 10 flipped.
      fb[10] = fb[10] ^ 8'h01;
      send(0, fb, 7, 0, -1);
      chk("crcerr_err", 0, last_err[0], 4'b0100);
      chk("crcerr_ecnt", 0, err_cnt[0], 32'd1);

      // 40-byte frame, then a 64-byte frame plus one stray dibble.
      send(0, make_frame(36), 7, 0, -1);
      chk("short_err", 0, last_err[0], 4'b0010);
      send(0, make_frame(60), 7, 1, -1);
      chk("incomplete_err", 0, last_err[0], 4'b0001);
      chk("incomplete_len", 0, last_len[0], 11'd64);

      // Six preamble bytes only: ignored; the next frame is received.
      send(0, make_frame(60), 6, 0, -1);
      send(0, make_frame(60), 7, 0, -1);
      chk("after_bad_pre_err", 0, last_err[0], 4'b0000);

      // Reset at payload byte 30, then a clean frame.
      send(0, make_frame(60), 7, 0, 30);
      send(0, make_frame(70), 7, 0, -1);
      chk("after_abort_fcnt", 0, frame_cnt[0], 32'd1);
      chk("after_abort_err", 0, last_err[0], 4'b0000);

      // MII: 1600-byte good frame.
      send(1, make_frame(1596), 7, 0, -1);
      chk("long_len", 1, last_len[1], 11'd1600);
      chk("long_err", 1, last_err[1], 4'b1000);

      // Random mix of good, corrupted, ragged and tiny frames on both widths.
      for (int r = 0; r < 16; r++) begin
         inst = r % 2;
         mode = $urandom_range(0, 3);
         bpb  = (inst == 0) ? 4 : 2;
         fb.delete();
         if (mode == 3) begin
            repeat ($urandom_range(0, 6)) fb.push_back(8'($urandom));
         end else begin
            fb = make_frame($urandom_range(1, 110));
         end
         if (mode == 1) begin
            pos     = $urandom_range(0, fb.size() - 1);
            fb[pos] = fb[pos] ^ (8'd1 << $urandom_range(0, 7));
         end
         send(inst, fb, 7, (mode == 2) ? $urandom_range(1, bpb - 1) : 0, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
